// File: rtl/boruss_mem_arbiter.sv
// boruss_mem_arbiter: round-robin arbiter giving three requesters access to one synchronous-read memory
module boruss_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            gnt_id,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_GRANT = 2'b01, S_ACK = 2'b10} state_t;
  state_t              r_state;
  logic [1:0]          r_last, r_gnt;
  logic                r_we, r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [2:0]          r_ack;
  logic [2:0]          w_req_m;
  logic [1:0]          w_s0, w_s1, w_win;
  logic                w_any;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  // in ACK the requester just served is masked so the others get a turn first
  always_comb begin
    w_req_m = (r_state == S_ACK) ? (req & ~(3'b001 << r_gnt)) : req;
    w_any   = |w_req_m;
    w_s0    = (r_last == 2'd0) ? 2'd1 : (r_last == 2'd1) ? 2'd2 : 2'd0;
    w_s1    = (r_last == 2'd0) ? 2'd2 : (r_last == 2'd1) ? 2'd0 : 2'd1;
    w_win   = w_req_m[w_s0] ? w_s0 : w_req_m[w_s1] ? w_s1 : r_last;
    w_addr  = (w_win == 2'd0) ? req_addr[0 +: ADDR_W] :
              (w_win == 2'd1) ? req_addr[ADDR_W +: ADDR_W] : req_addr[2*ADDR_W +: ADDR_W];
    w_wdata = (w_win == 2'd0) ? req_wdata[0 +: DATA_W] :
              (w_win == 2'd1) ? req_wdata[DATA_W +: DATA_W] : req_wdata[2*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd2;
      r_gnt    <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ack    <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_ACK: begin
          if (r_state == S_ACK && !r_we) r_rdata <= mem_rdata;
          if (w_any) begin
            r_state  <= S_GRANT;
            r_last   <= w_win;
            r_gnt    <= w_win;
            r_we     <= req_we[w_win];
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_mem_en <= 1'b1;
            r_mem_we <= req_we[w_win];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          r_state <= S_ACK;
          r_ack   <= 3'b001 << r_gnt;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // the memory registers read data at the end of GRANT; pass it through during a read ack
  assign rdata     = (r_state == S_ACK && !r_we) ? mem_rdata : r_rdata;
  assign ack       = r_ack;
  assign gnt_id    = r_gnt;
  assign busy      = (r_state != S_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
endmodule
